// File: rtl/bus_mem_responder.sv
// Bus target for the 16-bit core: word RAM plus a small I/O page (GPIO, cycle
// counter, bus-error status). Reads answer one cycle later on the shared DATA bus.
module bus_mem_responder #(
  parameter int          ADDR_BITS = 10,
  parameter logic [15:0] IO_BASE   = 16'hFF00
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        RD,
  input  logic        WR,
  input  logic [15:0] ADDR,
  inout  wire  [15:0] DATA,
  input  logic [15:0] GPIO_IN,
  output logic [15:0] GPIO_OUT,
  output logic        BUS_ERR
);

  localparam int RAM_WORDS = 1 << ADDR_BITS;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_t;

  state_t state_reg, state_next;

  logic [15:0] mem [RAM_WORDS];
  logic [15:0] ram_q_reg;
  logic        sel_ram_reg;
  logic [15:0] io_q_reg;

  logic [15:0] cycle_reg;
  logic [15:0] sync1_reg, sync2_reg;
  logic [15:0] gpio_out_reg;
  logic        err_reg;
  logic [7:0]  err_cnt_reg;

  logic [ADDR_BITS-1:0] ram_addr;
  logic [15:0] io_off;
  logic        in_ram, in_io, unmapped;
  logic        sel_gpo, sel_status;
  logic        rd_ok, wr_ok;
  logic        err_event, status_clr;
  logic [15:0] io_rd_mux;
  logic [15:0] resp_data;
  logic        data_oe;

  // Address decode
  assign ram_addr   = ADDR[ADDR_BITS-1:0];
  assign in_ram     = (ADDR[15:ADDR_BITS] == '0);
  assign in_io      = (ADDR >= IO_BASE);
  assign io_off     = ADDR - IO_BASE;
  assign unmapped   = !in_ram && !in_io;
  assign sel_gpo    = in_io && (io_off == 16'd0);
  assign sel_status = in_io && (io_off == 16'd3);

  // A simultaneous RD and WR is an error and performs neither access.
  assign rd_ok = RD && !WR;
  assign wr_ok = WR && !RD;

  assign err_event  = (RD && WR) || ((RD || WR) && unmapped);
  // Any write to STATUS clears it, and takes priority over a coincident error.
  assign status_clr = WR && sel_status;

  always_comb begin
    io_rd_mux = 16'h0000;
    if (in_io) begin
      case (io_off)
        16'd0:   io_rd_mux = gpio_out_reg;
        16'd1:   io_rd_mux = sync2_reg;
        16'd2:   io_rd_mux = cycle_reg;
        16'd3:   io_rd_mux = {err_cnt_reg, 7'b0000000, err_reg};
        default: io_rd_mux = 16'h0000;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state and bus drive enable
  always_comb begin
    state_next = ST_IDLE;
    data_oe    = 1'b0;
    if (rd_ok) begin
      state_next = ST_RESP;
    end
    if ((state_reg == ST_RESP) && !WR) begin
      data_oe = 1'b1;
    end
  end

  // Word RAM: no reset so it maps onto block RAM with a registered read port.
  always_ff @(posedge CLK) begin
    if (wr_ok && in_ram) begin
      mem[ram_addr] <= DATA;
    end
    if (rd_ok && in_ram) begin
      ram_q_reg <= mem[ram_addr];
    end
  end

  // Response source select and the I/O half of the response register
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      sel_ram_reg <= 1'b0;
      io_q_reg    <= 16'h0000;
    end else if (rd_ok) begin
      sel_ram_reg <= in_ram;
      io_q_reg    <= io_rd_mux;
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      cycle_reg <= 16'h0000;
      sync1_reg <= 16'h0000;
      sync2_reg <= 16'h0000;
    end else begin
      cycle_reg <= cycle_reg + 16'd1;
      sync1_reg <= GPIO_IN;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      gpio_out_reg <= 16'h0000;
    end else if (wr_ok && sel_gpo) begin
      gpio_out_reg <= DATA;
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      err_reg     <= 1'b0;
      err_cnt_reg <= 8'h00;
    end else if (status_clr) begin
      err_reg     <= 1'b0;
      err_cnt_reg <= 8'h00;
    end else if (err_event) begin
      err_reg <= 1'b1;
      if (err_cnt_reg != 8'hFF) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end
  end

  assign resp_data = sel_ram_reg ? ram_q_reg : io_q_reg;
  assign DATA      = data_oe ? resp_data : 16'hzzzz;
  assign GPIO_OUT  = gpio_out_reg;
  assign BUS_ERR   = err_reg;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: directed vector table, hand-written corner
// sequences and a randomized run against an array-based reference model.
module tb_bus_mem_responder;

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        RD = 1'b0;
  logic        WR = 1'b0;
  logic [15:0] ADDR = 16'h0000;
  logic [15:0] GPIO_IN = 16'h0000;
  logic [15:0] GPIO_OUT;
  logic        BUS_ERR;

  // Pulled-up bus: an undriven DATA reads back as FFFF.
  tri1 [15:0]  data_bus;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_wdata = 16'h0000;
  assign data_bus = tb_drv ? tb_wdata : 16'hzzzz;

  always #5 CLK = ~CLK;

  bus_mem_responder #(.ADDR_BITS(10), .IO_BASE(16'hFF00)) dut (
    .CLK(CLK), .RES(RES), .RD(RD), .WR(WR), .ADDR(ADDR), .DATA(data_bus),
    .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT), .BUS_ERR(BUS_ERR)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bus transaction: inputs change at the falling edge, pre is sampled
  // before the rising edge, post 1 time unit after it.
  task automatic do_cycle(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, output logic [15:0] pre,
                          output logic [15:0] post);
    @(negedge CLK);
    RD = rd; WR = wr; ADDR = addr; tb_drv = wr; tb_wdata = wdata;
    #1 pre = data_bus;
    @(posedge CLK);
    #1 post = data_bus;
    $display("[TB] t=%0t rd=%0b wr=%0b addr=%h wdata=%h pre=%h post=%h err=%0b",
             $time, rd, wr, addr, wdata, pre, post, BUS_ERR);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          chk;     // 0 none, 1 check post, 2 check pre
    logic [15:0] exp;
    logic        chk_err;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [15:0] wdata, input int chk, input logic [15:0] exp,
                     input logic chk_err, input logic exp_err, input string name);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.chk = chk; v.exp = exp;
    v.chk_err = chk_err; v.exp_err = exp_err; v.name = name;
    vt.push_back(v);
  endtask

  // Reference model state
  logic [15:0] m_mem [1024];
  logic [15:0] m_gpo;
  logic [15:0] m_gpi;
  logic        m_err;
  int          m_cnt;

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (a < 16'd1024)       return m_mem[a];
    else if (a < 16'hFF00)  return 16'h0000;
    else if (a == 16'hFF00) return m_gpo;
    else if (a == 16'hFF01) return m_gpi;
    else if (a == 16'hFF03) return {m_cnt[7:0], 7'b0000000, m_err};
    else                    return 16'h0000;
  endfunction

  task automatic model_update(input logic rd, input logic wr, input logic [15:0] a,
                              input logic [15:0] d);
    logic unm;
    unm = (a >= 16'd1024) && (a < 16'hFF00);
    if (wr && a == 16'hFF03) begin
      m_err = 1'b0; m_cnt = 0;
    end else if ((rd && wr) || ((rd || wr) && unm)) begin
      m_err = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
    if (wr && !rd) begin
      if (a < 16'd1024) m_mem[a] = d;
      if (a == 16'hFF00) m_gpo = d;
    end
  endtask

  logic [15:0] pre, post, c0, c1, c2, a, d;
  int          w, kind, op;
  logic        rd, wr;

  initial begin
    // Reset state
    #1 RES = 1'b0;
    #2;
    check("reset_data_hiz", data_bus, 16'hFFFF);
    check("reset_gpio_out", GPIO_OUT, 16'h0000);
    check("reset_bus_err", {15'd0, BUS_ERR}, 16'h0000);
    @(negedge CLK);
    RES = 1'b1;

    // Directed vector table
    add(0, 1, 16'h0010, 16'hA5C3, 0, 16'h0000, 0, 0, "wr_0010");
    add(1, 0, 16'h0010, 16'h0000, 1, 16'hA5C3, 1, 0, "rd_0010");
    add(0, 0, 16'h0000, 16'h0000, 1, 16'hFFFF, 0, 0, "hiz_after_read");
    add(0, 1, 16'h0000, 16'h1111, 0, 16'h0000, 0, 0, "wr_0000");
    add(0, 1, 16'h0001, 16'h2222, 0, 16'h0000, 0, 0, "wr_0001");
    add(1, 0, 16'h0000, 16'h0000, 1, 16'h1111, 0, 0, "b2b_rd_0000");
    add(1, 0, 16'h0001, 16'h0000, 1, 16'h2222, 0, 0, "b2b_rd_0001");
    add(0, 1, 16'h0002, 16'hBEEF, 2, 16'hBEEF, 0, 0, "wr_after_rd_no_contention");
    add(1, 0, 16'h0002, 16'h0000, 1, 16'hBEEF, 0, 0, "rd_0002");
    add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, "idle");
    add(1, 0, 16'h0800, 16'h0000, 1, 16'h0000, 1, 1, "rd_unmapped");
    add(1, 1, 16'h0005, 16'h0000, 0, 16'h0000, 1, 1, "rd_wr_both");
    add(1, 0, 16'hFF03, 16'h0000, 1, 16'h0201, 1, 1, "rd_status");
    add(0, 1, 16'hFF03, 16'h1234, 0, 16'h0000, 1, 0, "wr_status_clear");
    add(1, 0, 16'hFF03, 16'h0000, 1, 16'h0000, 1, 0, "rd_status_cleared");
    add(0, 1, 16'hFF00, 16'h00FF, 0, 16'h0000, 0, 0, "wr_gpio_out");
    add(1, 0, 16'hFF00, 16'h0000, 1, 16'h00FF, 0, 0, "rd_gpio_out");
    add(1, 0, 16'hFF10, 16'h0000, 1, 16'h0000, 1, 0, "rd_reserved");
    add(0, 1, 16'hFF20, 16'h5555, 0, 16'h0000, 1, 0, "wr_reserved_no_err");
    foreach (vt[i]) begin
      do_cycle(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, pre, post);
      if (vt[i].chk == 1) check(vt[i].name, post, vt[i].exp);
      if (vt[i].chk == 2) check(vt[i].name, pre, vt[i].exp);
      if (vt[i].chk_err) check({vt[i].name, "_err"}, {15'd0, BUS_ERR}, {15'd0, vt[i].exp_err});
    end
    check("gpio_out_pin", GPIO_OUT, 16'h00FF);

    // GPIO_IN through the synchronizer
    GPIO_IN = 16'h1234;
    do_cycle(0, 0, 16'h0000, 16'h0000, pre, post);
    do_cycle(0, 0, 16'h0000, 16'h0000, pre, post);
    do_cycle(1, 0, 16'hFF01, 16'h0000, pre, post);
    check("gpio_in_read", post, 16'h1234);

    // CYCLE: run up to just below the wrap, then sample 5 edges apart
    do_cycle(1, 0, 16'hFF02, 16'h0000, pre, c0);
    RD = 1'b0; WR = 1'b0; tb_drv = 1'b0;
    w = int'(16'(16'hFFFD - c0));
    repeat (w) @(posedge CLK);
    do_cycle(1, 0, 16'hFF02, 16'h0000, pre, c1);
    check("cycle_pre_wrap", c1, 16'hFFFE);
    repeat (4) do_cycle(0, 0, 16'h0000, 16'h0000, pre, post);
    do_cycle(1, 0, 16'hFF02, 16'h0000, pre, c2);
    check("cycle_diff_wrap", 16'(c2 - c1), 16'd5);
    check("cycle_after_wrap", c2, 16'h0003);

    // Error counter saturation
    for (int i = 0; i < 300; i++) do_cycle(0, 1, 16'h0900, 16'(i), pre, post);
    do_cycle(1, 0, 16'hFF03, 16'h0000, pre, post);
    check("status_saturated", post, 16'hFF01);

    // Randomized run against the reference model
    m_gpi = 16'($urandom);
    GPIO_IN = m_gpi;
    m_err = 1'b0; m_cnt = 0;
    do_cycle(0, 1, 16'hFF03, 16'h0000, pre, post);
    m_gpo = 16'($urandom);
    do_cycle(0, 1, 16'hFF00, m_gpo, pre, post);
    for (int i = 0; i < 1024; i++) begin
      m_mem[i] = 16'($urandom);
      do_cycle(0, 1, 16'(i), m_mem[i], pre, post);
    end
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3, 4: a = 16'($urandom_range(0, 1023));
        5:             a = 16'($urandom_range(1024, 16'hFEFF));
        6:             a = 16'hFF00;
        7:             a = 16'hFF01;
        8:             a = 16'hFF03;
        default:       a = 16'($urandom_range(16'hFF04, 16'hFFFF));
      endcase
      op = $urandom_range(0, 7);
      rd = (op >= 1 && op <= 3) || op == 7;
      wr = (op >= 4);
      if (rd && wr && a == 16'hFF03) a = 16'hFF05;
      d = 16'($urandom);
      c0 = model_read(a);
      do_cycle(rd, wr, a, d, pre, post);
      if (rd && !wr) check("rand_read", post, c0);
      if (!rd && !wr) check("rand_idle_hiz", post, 16'hFFFF);
      model_update(rd, wr, a, d);
      check("rand_bus_err", {15'd0, BUS_ERR}, {15'd0, m_err});
      check("rand_gpio_out", GPIO_OUT, m_gpo);
    end

    // Reset in the middle of a read response
    do_cycle(0, 1, 16'h0010, 16'h6C6C, pre, post);
    do_cycle(0, 1, 16'h0800, 16'h0000, pre, post);
    do_cycle(0, 1, 16'hFF00, 16'h1357, pre, post);
    do_cycle(1, 0, 16'h0010, 16'h0000, pre, post);
    check("pre_reset_read", post, 16'h6C6C);
    #2 RES = 1'b0;
    RD = 1'b0; WR = 1'b0; tb_drv = 1'b0;
    #1;
    check("reset_mid_resp_hiz", data_bus, 16'hFFFF);
    check("reset_mid_gpio_out", GPIO_OUT, 16'h0000);
    check("reset_mid_bus_err", {15'd0, BUS_ERR}, 16'h0000);
    @(posedge CLK);
    #1 RES = 1'b1;
    do_cycle(1, 0, 16'hFF02, 16'h0000, pre, post);
    check("no_resp_after_reset", pre, 16'hFFFF);
    check("cycle_after_reset", post, 16'h0000);
    do_cycle(1, 0, 16'h0010, 16'h0000, pre, post);
    check("read_after_reset", post, 16'h6C6C);
    do_cycle(0, 0, 16'h0000, 16'h0000, pre, post);
    check("final_hiz", post, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
